// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: parametrised UART RX/TX buffer; define UART_FIFO_FWFT_EN for first-word-fall-through reads.
// Latency: write counted in level next cycle; read data 1 cycle after rd_en (0 cycles in FWFT mode).
// Backpressure: write at full (without read) and read at empty are dropped and latch sticky overflow/underflow.
module uart_sync_fifo #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = (1 << ADDR_W) - 2,
  parameter int AEMPTY_TH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_L    = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_L    = AEMPTY_TH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              rd_ok;
  logic              wr_ok;

  // Flags come from the registered level only, never from this cycle's requests.
  assign fifo_empty   = (level == '0);
  assign fifo_full    = (level == DEPTH_L);
  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);

  // A read at full frees the head slot, so the paired write is accepted too.
  assign rd_ok = rd_en && !fifo_empty;
  assign wr_ok = wr_en && (!fifo_full || rd_en);

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        level <= level + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        level <= level - 1'b1;
      end
      // A new error in the same cycle as clr_err keeps the flag set.
      if (wr_en && !wr_ok) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_en && !rd_ok) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

`ifdef UART_FIFO_FWFT_EN
  assign rd_data  = mem[rptr];
  assign rd_valid = !fifo_empty && !rst;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) begin
        rd_data <= mem[rptr];
      end
    end
  end
`endif

endmodule

// File: doc/uart_sync_fifo.md
# uart_sync_fifo

Parametrised synchronous FIFO for the UART datapath, the next generation of the fixed 4×8 RX buffer. Used as the RX buffer after the UART receiver and as the TX buffer ahead of the transmitter. Adds configurable width and depth, a level output, and almost-full/almost-empty thresholds. Also defines simultaneous read/write at full and empty, adds sticky overflow/underflow error flags, and offers an optional first-word-fall-through read mode.

## Interface
- DATA_W, 8, word width in bits
- ADDR_W, 4, log2 of depth; DEPTH = 2**ADDR_W; legal range 1..8
- AFULL_TH, DEPTH-2, almost_full asserts when level >= AFULL_TH; legal range 1..DEPTH
- AEMPTY_TH, 1, almost_empty asserts when level <= AEMPTY_TH; legal range 0..DEPTH-1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  DATA_W  write word
- rd_en  in  1  read (pop) request
- rd_data  out  DATA_W  read word
- rd_valid  out  1  rd_data qualifier
- fifo_empty  out  1  level == 0
- fifo_full  out  1  level == DEPTH
- almost_full  out  1  level >= AFULL_TH
- almost_empty  out  1  level <= AEMPTY_TH
- level  out  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected
- clr_err  in  1  clears overflow and underflow

## Operation
- Storage: DEPTH×DATA_W register array; not reset. wptr and rptr are ADDR_W bits and wrap modulo DEPTH naturally. level is a separate ADDR_W+1-bit counter.
- Status outputs are decoded from the registered level only. There is no combinational path from wr_en/rd_en to any status output.
- Read accepted (rd_ok) = rd_en && !fifo_empty.
- Write accepted (wr_ok) = wr_en && (!fifo_full || rd_en).
  - At full, a simultaneous read frees the slot, so both are accepted and level is unchanged.
- At empty, a simultaneous read and write: only the write is accepted. There is no bypass. The read is rejected and sets underflow.
- Level update:
  - +1 on wr_ok && !rd_ok
  - −1 on rd_ok && !wr_ok
  - unchanged when both or neither are accepted
  - level never exceeds DEPTH and never goes below 0.
- Error flags:
  - overflow is set by wr_en && !wr_ok; underflow is set by rd_en && !rd_ok.
  - clr_err clears both. If set and clear occur in the same cycle, set wins.
  - The rejected write does not modify memory or pointers.
- Reset (any cycle, including mid-burst):
  - wptr = rptr = 0, level = 0, rd_data = 0, rd_valid = 0, overflow = underflow = 0.
  - fifo_empty = 1, fifo_full = 0, almost_empty = 1, and almost_full = (AFULL_TH == 0 ? 1 : 0), which is 0 for all legal values.
  - Stored data is discarded. rst has priority over every other input.

## Timing
- Write: a word accepted at edge N is counted in level after edge N. fifo_empty falls in the cycle following edge N.
- Standard read (macro undefined):
  - rd_ok at edge N → rd_data = mem[rptr] and rd_valid = 1 after edge N. Latency is 1 cycle.
  - rd_valid is a single-cycle pulse per accepted read.
  - rd_data holds its last value when no read is accepted.
- The word read at full with a simultaneous write is the old head word. The new word lands behind it.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- UART_FIFO_FWFT_EN defined: first-word-fall-through mode.
  - rd_data = mem[rptr] as an asynchronous read of the array.
  - rd_valid = !fifo_empty, with zero latency. rd_en acknowledges (pops) the presented word.
  - The rd_data reset value is don't-care. rd_valid is 0 in reset.
- UART_FIFO_FWFT_EN undefined: standard registered read as described in Timing.
- Flag, level, and error behaviour is identical in both modes.

## Test plan
Parameters: DATA_W=8, ADDR_W=2, AFULL_TH=3, AEMPTY_TH=1.

- Fill and drain:
  - Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles → level 1,2,3,4; almost_full asserts at level 3; fifo_full asserts at level 4.
  - Then 4 reads → 0x11..0x44 in order, each one cycle after its rd_en (standard mode); fifo_empty = 1 after the last.
- Overflow: at full, wr_en alone with 0x55 → level stays 4, overflow = 1, and the next read returns 0x11. Assert clr_err → overflow = 0.
- Simultaneous at full: rd_en + wr_en(0x66) → rd_data = head (0x11), level stays 4; a subsequent drain ends with 0x66.
- Simultaneous at empty: rd_en + wr_en(0x77) → underflow = 1, level = 1, rd_valid = 0; next read returns 0x77.
- Wrap-around: 10 write-then-read pairs with values 0x00..0x09 → output sequence matches, and pointers wrap at least twice.
- Reset mid-operation: with level 3, pulse rst → level 0, fifo_empty = 1, rd_valid = 0, flags 0. A following write of 0xA5 then a read returns 0xA5.
- Repeat all scenarios with UART_FIFO_FWFT_EN defined: rd_data shows the head word whenever rd_valid = 1.
